// File: rtl/rv32i_types.sv
// Shared RV32I types: base opcode enum and the architectural word type.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    OpLoad    = 7'b0000011,
    OpMiscMem = 7'b0001111,
    OpImm     = 7'b0010011,
    OpAuipc   = 7'b0010111,
    OpStore   = 7'b0100011,
    OpReg     = 7'b0110011,
    OpLui     = 7'b0110111,
    OpBranch  = 7'b1100011,
    OpJalr    = 7'b1100111,
    OpJal     = 7'b1101111,
    OpSystem  = 7'b1110011
  } rv32i_opcode;

  function automatic rv32i_word sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/ir_queue_if.sv
// Fetch/decode handshake bundle for ir_queue; master is the fetch/decode side,
// slave is the queue itself.
interface ir_queue_if
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  rv32i_word        in_inst;
  rv32i_word        in_pc;
  logic             out_valid;
  logic             out_ready;
  rv32i_word        out_pc;
  rv32i_opcode      opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  rv32i_word        i_imm;
  rv32i_word        s_imm;
  rv32i_word        b_imm;
  rv32i_word        u_imm;
  rv32i_word        j_imm;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
    input  i_imm, s_imm, b_imm, u_imm, j_imm, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
    output i_imm, s_imm, b_imm, u_imm, j_imm, count
  );

endinterface

// File: rtl/ir_decode.sv
// Combinational RV32I field and immediate extractor; reusable by later stages.
module ir_decode
  import rv32i_types::*;
(
  input  rv32i_word   inst,
  output rv32i_opcode opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output rv32i_word   i_imm,
  output rv32i_word   s_imm,
  output rv32i_word   b_imm,
  output rv32i_word   u_imm,
  output rv32i_word   j_imm
);

  always_comb begin
    opcode = rv32i_opcode'(inst[6:0]);
    funct3 = inst[14:12];
    funct7 = inst[31:25];
    rs1    = inst[19:15];
    rs2    = inst[24:20];
    rd     = inst[11:7];
    i_imm  = sext12(inst[31:20]);
    s_imm  = sext12({inst[31:25], inst[11:7]});
    b_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u_imm  = {inst[31:12], 12'h000};
    j_imm  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  end

endmodule

// File: rtl/ir_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode with head-entry decode.
// Define IR_QUEUE_BYPASS_EN to forward in_inst/in_pc combinationally when empty.
module ir_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  ir_queue_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  rv32i_word        mem_inst_q [DEPTH];
  rv32i_word        mem_pc_q   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      empty, full, bypass, enq, deq;
  rv32i_word head_inst;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

`ifdef IR_QUEUE_BYPASS_EN
  assign bypass = empty && bus.in_valid && !bus.flush;
`else
  assign bypass = 1'b0;
`endif

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty || bypass;
  assign bus.count     = count_q;

  // A bypassed word taken by decode this cycle never enters storage.
  assign enq = bus.in_valid && !full && !(bypass && bus.out_ready);
  assign deq = !empty && bus.out_ready;

  assign head_inst  = bypass ? bus.in_inst : mem_inst_q[rd_ptr_q];
  assign bus.out_pc = bypass ? bus.in_pc : mem_pc_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (enq && !bus.flush) begin
        mem_inst_q[wr_ptr_q] <= bus.in_inst;
        mem_pc_q[wr_ptr_q]   <= bus.in_pc;
      end
    end
  end

  ir_decode u_decode (
    .inst   (head_inst),
    .opcode (bus.opcode),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .rd     (bus.rd),
    .i_imm  (bus.i_imm),
    .s_imm  (bus.s_imm),
    .b_imm  (bus.b_imm),
    .u_imm  (bus.u_imm),
    .j_imm  (bus.j_imm)
  );

endmodule
